// File: rtl/car_pkg.sv
// car_pkg: shared types for the car drive/steer controller.
// Drive-state enum, direction code, stepper coil table, target decode.
package car_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN_FWD  = 3'd1,
    RUN_REV  = 3'd2,
    STOPPING = 3'd3,
    BRAKE    = 3'd4
  } drive_state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_FWD  = 2'd1,
    DIR_REV  = 2'd2
  } dir_e;

  // Wave drive, entry 0 is the rightmost nibble.
  localparam logic [3:0][3:0] COIL_SEQ = {
    4'b1000, 4'b0100, 4'b0010, 4'b0001
  };

  function automatic dir_e target_dir(
    input logic f,
    input logic b
  );
    unique case ({f, b})
      2'b10:   return DIR_FWD;
      2'b01:   return DIR_REV;
      default: return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/car_pwm_gen.sv
// car_pwm_gen: free-running PWM counter and registered comparator.
// Ports: clk, rst, i_en (gate), i_duty, o_pwm.
module car_pwm_gen #(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [PWM_W-1:0] i_duty,
  output logic             o_pwm
);

  logic [PWM_W-1:0] r_cnt;
  logic             r_pwm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_pwm <= 1'b0;
    end else begin
      r_cnt <= r_cnt + PWM_W'(1);
      r_pwm <= i_en && (r_cnt < i_duty);
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/car_motion_ctrl.sv
// car_motion_ctrl: ramped DC drive FSM, safe reversal, limited stepper.
// Ports: clk, rst, manual/brake/centre/auto/line inputs; motor_ft/bk/pwm,
// duty, step_coil, steer_pos, drive_state. Option: CAR_LINE_FOLLOW_EN.
module car_motion_ctrl
  import car_pkg::*;
#(
  parameter int PWM_W     = 8,
  parameter int DUTY_MAX  = 200,
  parameter int DUTY_AUTO = 120,
  parameter int RAMP_DIV  = 50000,
  parameter int STEP_DIV  = 100000,
  parameter int STEER_MAX = 64,
  localparam int SW = $clog2(STEER_MAX) + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 forward,
  input  logic                 backward,
  input  logic                 left,
  input  logic                 right,
  input  logic                 car_break_signal,
  input  logic                 init_rotate_signal,
  input  logic                 auto_mode_signal,
  input  logic                 left_line_signal,
  input  logic                 right_line_signal,
  output logic                 motor_ft,
  output logic                 motor_bk,
  output logic                 motor_pwm,
  output logic [PWM_W-1:0]     duty,
  output logic [3:0]           step_coil,
  output logic signed [SW-1:0] steer_pos,
  output logic [2:0]           drive_state
);

  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);
  localparam logic [TW-1:0] STEP_LAST = TW'(STEP_DIV - 1);
  localparam logic [PWM_W-1:0] CR_MAN  = PWM_W'(DUTY_MAX);
  localparam logic [PWM_W-1:0] CR_AUTO = PWM_W'(DUTY_AUTO);
  localparam logic signed [SW-1:0] POS_MAX  = SW'(STEER_MAX);
  localparam logic signed [SW-1:0] POS_MIN  = -POS_MAX;
  localparam logic signed [SW-1:0] POS_ZERO = '0;
  localparam logic signed [SW-1:0] POS_ONE  = SW'(1);

  logic [RW-1:0] r_ramp_cnt;
  logic [TW-1:0] r_step_cnt;
  logic w_ramp_tick;
  logic w_step_tick;

  drive_state_e r_state, w_state_nxt;
  dir_e r_held, w_held_nxt;
  dir_e w_tgt;
  logic [PWM_W-1:0] r_duty, w_duty_nxt;
  logic [PWM_W-1:0] w_cruise;
  logic r_ft, r_bk;
  logic w_ft_nxt, w_bk_nxt;

  logic signed [SW-1:0] r_pos, w_pos_nxt;
  logic [1:0] r_phase, w_phase_nxt;
  logic [3:0] r_coil;

  logic w_f, w_b, w_l, w_r, w_ctr;

  assign w_ramp_tick = (r_ramp_cnt == RAMP_LAST);
  assign w_step_tick = (r_step_cnt == STEP_LAST);

  always_comb begin
    w_f      = forward;
    w_b      = backward;
    w_l      = left & ~right;
    w_r      = right & ~left;
    w_ctr    = init_rotate_signal;
    w_cruise = CR_MAN;
`ifdef CAR_LINE_FOLLOW_EN
    if (auto_mode_signal) begin
      w_f      = ~(left_line_signal & right_line_signal);
      w_b      = 1'b0;
      w_l      = left_line_signal & ~right_line_signal;
      w_r      = right_line_signal & ~left_line_signal;
      w_ctr    = ~left_line_signal & ~right_line_signal;
      w_cruise = CR_AUTO;
    end
`endif
  end

`ifndef CAR_LINE_FOLLOW_EN
  logic w_unused;
  assign w_unused = ^{auto_mode_signal, left_line_signal,
                      right_line_signal, CR_AUTO};
`endif

  assign w_tgt = target_dir(w_f, w_b);

  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    w_held_nxt  = r_held;
    if (car_break_signal) begin
      w_state_nxt = BRAKE;
      w_duty_nxt  = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_duty_nxt = '0;
          if (w_tgt == DIR_FWD) begin
            w_state_nxt = RUN_FWD;
            w_held_nxt  = DIR_FWD;
          end else if (w_tgt == DIR_REV) begin
            w_state_nxt = RUN_REV;
            w_held_nxt  = DIR_REV;
          end
        end
        RUN_FWD, RUN_REV: begin
          if (w_tgt != r_held) begin
            w_state_nxt = STOPPING;
          end else if (w_ramp_tick) begin
            if (r_duty < w_cruise)
              w_duty_nxt = r_duty + PWM_W'(1);
            else if (r_duty > w_cruise)
              w_duty_nxt = r_duty - PWM_W'(1);
          end
        end
        STOPPING: begin
          if (r_duty == '0)
            w_state_nxt = IDLE;
          else if (w_tgt == r_held)
            w_state_nxt = (r_held == DIR_FWD) ? RUN_FWD : RUN_REV;
          else if (w_ramp_tick)
            w_duty_nxt = r_duty - PWM_W'(1);
        end
        default: begin
          w_state_nxt = IDLE;
          w_duty_nxt  = '0;
        end
      endcase
    end
  end

  // Pins follow the held direction while coasting down in STOPPING.
  always_comb begin
    w_ft_nxt = 1'b0;
    w_bk_nxt = 1'b0;
    unique case (w_state_nxt)
      RUN_FWD:  w_ft_nxt = 1'b1;
      RUN_REV:  w_bk_nxt = 1'b1;
      STOPPING: begin
        w_ft_nxt = (w_held_nxt == DIR_FWD);
        w_bk_nxt = (w_held_nxt == DIR_REV);
      end
      BRAKE: begin
        w_ft_nxt = 1'b1;
        w_bk_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_pos_nxt   = r_pos;
    w_phase_nxt = r_phase;
    if (w_step_tick) begin
      if (w_l) begin
        if (r_pos > POS_MIN) begin
          w_pos_nxt   = r_pos - POS_ONE;
          w_phase_nxt = r_phase - 2'd1;
        end
      end else if (w_r) begin
        if (r_pos < POS_MAX) begin
          w_pos_nxt   = r_pos + POS_ONE;
          w_phase_nxt = r_phase + 2'd1;
        end
      end else if (w_ctr && (r_pos != POS_ZERO)) begin
        if (r_pos > POS_ZERO) begin
          w_pos_nxt   = r_pos - POS_ONE;
          w_phase_nxt = r_phase - 2'd1;
        end else begin
          w_pos_nxt   = r_pos + POS_ONE;
          w_phase_nxt = r_phase + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ramp_cnt <= '0;
      r_step_cnt <= '0;
      r_state    <= IDLE;
      r_held     <= DIR_NONE;
      r_duty     <= '0;
      r_ft       <= 1'b0;
      r_bk       <= 1'b0;
      r_pos      <= '0;
      r_phase    <= 2'd0;
      r_coil     <= COIL_SEQ[0];
    end else begin
      r_ramp_cnt <= w_ramp_tick ? '0 : r_ramp_cnt + RW'(1);
      r_step_cnt <= w_step_tick ? '0 : r_step_cnt + TW'(1);
      r_state    <= w_state_nxt;
      r_held     <= w_held_nxt;
      r_duty     <= w_duty_nxt;
      r_ft       <= w_ft_nxt;
      r_bk       <= w_bk_nxt;
      r_pos      <= w_pos_nxt;
      r_phase    <= w_phase_nxt;
      r_coil     <= COIL_SEQ[w_phase_nxt];
    end
  end

  car_pwm_gen #(
    .PWM_W(PWM_W)
  ) u_pwm (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_state_nxt != BRAKE),
    .i_duty(w_duty_nxt),
    .o_pwm (motor_pwm)
  );

  assign motor_ft    = r_ft;
  assign motor_bk    = r_bk;
  assign duty        = r_duty;
  assign step_coil   = r_coil;
  assign steer_pos   = r_pos;
  assign drive_state = r_state;

endmodule

// File: doc/car_motion_ctrl.md
# car_motion_ctrl

Parametrised drive/steer controller for the remote-controlled car. It replaces the fixed-speed DC-motor and stepper paths with four functions:
- soft-start/soft-stop duty ramping on the rear DC motor;
- a safe reversal sequence;
- a position-tracked, range-limited steering stepper;
- an optional line-follow auto mode.

It sits between the debounced command signals and the motor driver pins, on the single system clock.

## Interface
Parameters:
- PWM_W, 8: duty/PWM counter width.
- DUTY_MAX, 200: manual cruise duty (≤ 2^PWM_W−1).
- DUTY_AUTO, 120: auto-mode cruise duty (≤ DUTY_MAX).
- RAMP_DIV, 50000: clk cycles per ramp tick (±1 duty per tick).
- STEP_DIV, 100000: clk cycles per steering step tick.
- STEER_MAX, 64: steering limit in steps, each side of centre.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset, synchronous, active-high.
- forward / backward / left / right, in, 1 each: manual levels, already debounced.
- car_break_signal, in, 1: brake request (level).
- init_rotate_signal, in, 1: return steering to centre.
- auto_mode_signal, in, 1: select line-follow mode.
- left_line_signal / right_line_signal, in, 1 each: line sensors (1 = line seen).
- motor_ft / motor_bk / motor_pwm, out, 1 each: DC driver In1 / In2 / enable.
- duty, out, PWM_W: current duty.
- step_coil, out, 4: stepper coil drive.
- steer_pos, out, signed $clog2(STEER_MAX)+2: steering position; negative = left.
- drive_state, out, 3: FSM state, for debug LEDs.

## Operation
- Prescalers are free-running. The ramp tick fires when its counter reaches RAMP_DIV−1; the step tick fires when its counter reaches STEP_DIV−1.
- Target direction: forward&~backward → FWD; backward&~forward → REV; neither or both → NONE.
- Drive FSM states: IDLE, RUN_FWD, RUN_REV, STOPPING, BRAKE.
- IDLE (duty 0): target FWD → RUN_FWD; target REV → RUN_REV.
- RUN_x: on each ramp tick, duty +1 toward cruise, saturating at cruise.
  - Target NONE or the opposite direction → STOPPING.
- STOPPING: on each ramp tick, duty −1.
  - At duty 0 → IDLE.
  - A reversal therefore passes through IDLE for at least one cycle.
  - If the target returns to the held direction, go back to RUN_x without dropping to 0.
- BRAKE is entered from any state when car_break_signal=1, and has priority over everything.
  - duty 0 on the next cycle; motor_ft=motor_bk=1 (short brake).
  - Exit to IDLE on the first cycle with brake low.
- Driver pins: motor_ft=1 only in RUN_FWD, and in STOPPING after forward. motor_bk is the mirror for reverse. Both are 0 in IDLE.
- PWM: PWM_W-bit free-running counter; motor_pwm = (cnt < duty).
  - duty 0 → always low.
  - Forced low in BRAKE.
- Steering, on each step tick:
  - left&~right and pos > −STEER_MAX → pos−1 and phase−1.
  - right&~left and pos < STEER_MAX → pos+1 and phase+1.
  - Otherwise, if init_rotate_signal=1 and pos≠0 → step toward 0.
  - Otherwise hold.
  - At the limit, a further request holds pos and coils unchanged.
- Coil sequence (wave drive), indexed by a 2-bit phase that wraps 3↔0: 0001, 0010, 0100, 1000.

## Timing
- Reset values: duty 0, drive_state IDLE, steer_pos 0, phase 0 (step_coil 0001), motor_ft/bk/pwm 0, prescalers 0.
- Outputs are registered. FSM state changes one cycle after the causing input.
- Duty changes only on ramp-tick cycles.
- Ramp time 0 → cruise is cruise×RAMP_DIV cycles, with up to RAMP_DIV−1 cycles of initial phase offset.
- rst asserted mid-ramp or mid-step: all state returns to reset values on the next edge. There is no partial step.
- If brake and a ramp tick coincide, brake wins.
- If a steering request and centring coincide, the request wins.

## Configuration
- CAR_LINE_FOLLOW_EN defined: when auto_mode_signal=1, the manual forward/backward/left/right inputs are ignored.
  - Target FWD at DUTY_AUTO.
  - left_line only → steer left; right_line only → steer right.
  - Neither → centre.
  - Both → target NONE (ramp to stop).
  - Brake still has priority.
- CAR_LINE_FOLLOW_EN undefined: auto_mode_signal, left_line_signal and right_line_signal are ignored, and cruise is always DUTY_MAX.

## Structure
- Package car_pkg holds:
  - the drive-state enum (IDLE=0, RUN_FWD=1, RUN_REV=2, STOPPING=3, BRAKE=4);
  - the 4-entry coil-sequence constant;
  - the direction encoding (NONE/FWD/REV).
- One sub-module, car_pwm_gen: the counter plus comparator, parametrised by PWM_W.
- The FSM, ramp logic and steering logic stay in car_motion_ctrl.

## Test plan
All scenarios use PWM_W=4, DUTY_MAX=10, DUTY_AUTO=6, RAMP_DIV=4, STEP_DIV=3, STEER_MAX=2.
- Ramp up: hold forward → duty rises 1 per 4 cycles and saturates at 10 after ≤43 cycles; motor_ft=1, motor_bk=0; motor_pwm is high 10 of every 16 cycles.
- Reversal: at duty 10, switch to backward → STOPPING, duty falls to 0, IDLE for ≥1 cycle, then RUN_REV; motor_ft and motor_bk are never both 1.
- Brake: car_break_signal pulsed mid-ramp → next cycle duty 0, motor_ft=motor_bk=1, motor_pwm=0; on release → IDLE.
- Steering limit and centring:
  - hold right for 12 cycles → steer_pos saturates at +2, step_coil stops at 0100;
  - then init_rotate_signal → returns to 0, step_coil 0001.
- Auto mode (macro defined): auto_mode_signal=1 with left_line_signal=1 → duty ramps to 6 and steer_pos goes to −2; with both line sensors set → ramp to 0.
- Reset mid-operation: rst asserted during RUN_FWD at duty 7 with steer_pos=1 → next edge gives duty 0, IDLE, steer_pos 0, step_coil 0001.
